alu_cmd_sequencer: RTL and testbench

Command front-end for `my_alu`. It accepts operation commands (A, B, opcode, tag) over a valid/ready handshake and buffers them in a small FIFO. It issues one command per cycle to the ALU's operand inputs and tracks the ALU's one-cycle registered latency. It captures result and flags into a 2-entry output buffer and returns them tagged over a second valid/ready handshake, so upstream and downstream logic never see the ALU's un-stallable timing.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_fifo.sv | 45 ++++
 rtl/alu_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the my_alu command sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADDU = 3'd0,
        OP_ADDS = 3'd1,
        OP_SUBU = 3'd2,
        OP_SUBS = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_SHL  = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;

    localparam int OUT_BUF_DEPTH = 2;

endpackage

// File: rtl/alu_seq_fifo.sv
// Small FIFO with extra-bit pointers (full vs empty), synchronous clear and
// a combinational head read.
module alu_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         push_ok, pop_ok;

    assign count   = wptr - rptr;
    assign push_ok = push && !clr && (count != PW'(DEPTH));
    assign pop_ok  = pop && !clr && (count != '0);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for my_alu: command FIFO, one-cycle ALU latency tracking,
// 2-entry tagged result buffer. ALU_SEQ_STATS_EN adds issue/overflow counters.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUMBITS = 32,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] in_a,
    input  logic [NUMBITS-1:0] in_b,
    input  logic [2:0]         in_opcode,
    input  logic [TAGW-1:0]    in_tag,
    input  logic               flush,
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] out_result,
    output logic               out_carry,
    output logic               out_overflow,
    output logic               out_zero,
    output logic [TAGW-1:0]    out_tag
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [15:0]        stat_ovf
`endif
);
    localparam int CW  = TAGW + 3 + 2 * NUMBITS;
    localparam int RW  = TAGW + 3 + NUMBITS;
    localparam int CCW = $clog2(DEPTH) + 1;
    localparam int OCW = $clog2(OUT_BUF_DEPTH) + 1;
    localparam int OW  = OCW + 1;

    logic [CW-1:0]      cmd_wdata, cmd_rdata;
    logic [CCW-1:0]     cmd_count;
    logic               cmd_empty, cmd_full;
    logic [TAGW-1:0]    h_tag;
    logic [2:0]         h_op;
    logic [NUMBITS-1:0] h_a, h_b;

    logic [RW-1:0]      res_wdata, res_rdata;
    logic [OCW-1:0]     out_count;
    logic [TAGW-1:0]    o_tag;
    logic [NUMBITS-1:0] o_result;
    alu_flags_t         cap_flags, o_flags;

    logic               rdy_q, inflight;
    logic [TAGW-1:0]    inflight_tag;
    logic [NUMBITS-1:0] last_a, last_b;
    alu_op_t            last_op;
    logic               pop, issue, capture;
    logic [OW-1:0]      occ_next;

    assign cmd_empty = (cmd_count == '0);
    assign cmd_full  = (cmd_count == CCW'(DEPTH));
    assign in_ready  = rdy_q && !cmd_full && !flush;
    assign cmd_wdata = {in_tag, in_opcode, in_a, in_b};
    assign {h_tag, h_op, h_a, h_b} = cmd_rdata;

    // Result slots already promised: buffered, minus the one leaving, plus the one in the ALU.
    assign out_valid = (out_count != '0);
    assign pop       = out_valid && out_ready;
    assign occ_next  = OW'(out_count) - OW'(pop) + OW'(inflight);
    assign issue     = !cmd_empty && (occ_next < OW'(OUT_BUF_DEPTH)) && !flush;
    assign capture   = inflight && !flush;

    assign alu_a      = cmd_empty ? last_a : h_a;
    assign alu_b      = cmd_empty ? last_b : h_b;
    assign alu_opcode = cmd_empty ? last_op : h_op;

    assign cap_flags = '{carry: alu_carryout, overflow: alu_overflow, zero: alu_zero};
    assign res_wdata = {inflight_tag, cap_flags, alu_result};
    assign {o_tag, o_flags, o_result} = res_rdata;

    assign out_result   = out_valid ? o_result : '0;
    assign out_tag      = out_valid ? o_tag : '0;
    assign out_carry    = out_valid && o_flags.carry;
    assign out_overflow = out_valid && o_flags.overflow;
    assign out_zero     = out_valid && o_flags.zero;

    alu_seq_fifo #(.W(CW), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .push    (in_valid && in_ready),
        .wdata   (cmd_wdata),
        .pop     (issue),
        .rdata   (cmd_rdata),
        .count   (cmd_count)
    );

    alu_seq_fifo #(.W(RW), .DEPTH(OUT_BUF_DEPTH)) u_res_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .push    (capture),
        .wdata   (res_wdata),
        .pop     (pop),
        .rdata   (res_rdata),
        .count   (out_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q        <= 1'b0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            last_a       <= '0;
            last_b       <= '0;
            last_op      <= OP_ADDU;
        end else begin
            rdy_q    <= 1'b1;
            inflight <= issue;
            if (issue) begin
                inflight_tag <= h_tag;
                last_a       <= h_a;
                last_b       <= h_b;
                last_op      <= alu_op_t'(h_op);
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Saturating; deliberately untouched by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued <= '0;
            stat_ovf    <= '0;
        end else begin
            if (issue && (stat_issued != '1))
                stat_issued <= stat_issued + 32'd1;
            if (capture && alu_overflow && (stat_ovf != '1))
                stat_ovf <= stat_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural my_alu model.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic [3:0]  t;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic [2:0]  in_opcode, alu_opcode;
    logic [3:0]  in_tag, out_tag;
    logic        alu_carryout, alu_overflow, alu_zero;
    logic        out_carry, out_overflow, out_zero;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_issued;
    logic [15:0] stat_ovf;
`endif

    res_t exp_q[$];
    res_t got_q[$];
    res_t alu_q;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.NUMBITS(32), .DEPTH(4), .TAGW(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_opcode    (in_opcode),
        .in_tag       (in_tag),
        .flush        (flush),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_tag      (out_tag)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_ovf     (stat_ovf)
`endif
    );

    function automatic res_t alu_f(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [3:0] t);
        res_t        r;
        logic [32:0] s;
        r   = '0;
        r.t = t;
        case (op)
            3'd0, 3'd1: begin
                s   = {1'b0, a} + {1'b0, b};
                r.r = s[31:0];
                r.c = s[32];
                if (op == 3'd1) r.v = (a[31] == b[31]) && (r.r[31] != a[31]);
            end
            3'd2, 3'd3: begin
                s   = {1'b0, a} - {1'b0, b};
                r.r = s[31:0];
                r.c = s[32];
                if (op == 3'd3) r.v = (a[31] != b[31]) && (r.r[31] != a[31]);
            end
            3'd4:    r.r = a & b;
            3'd5:    r.r = a | b;
            3'd6:    r.r = a ^ b;
            default: r.r = a << b[4:0];
        endcase
        r.z = (r.r == 32'd0);
        return r;
    endfunction

    // my_alu stand-in: one registered stage, reset by ~reset_n.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) alu_q <= '0;
        else          alu_q <= alu_f(alu_a, alu_b, alu_opcode, 4'd0);
    end
    assign alu_result   = alu_q.r;
    assign alu_carryout = alu_q.c;
    assign alu_overflow = alu_q.v;
    assign alu_zero     = alu_q.z;

    // One cycle: drive at negedge, then record accepts and deliveries.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tg,
                        input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = iv; in_a = a; in_b = b; in_opcode = op; in_tag = tg;
        out_ready = ordy; flush = fl;
        #1;
        if (in_valid && in_ready) exp_q.push_back(alu_f(a, b, op, tg));
        if (out_valid && out_ready && !flush)
            got_q.push_back({out_result, out_carry, out_overflow, out_zero, out_tag});
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, ordy, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_chk++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL rst_out_result got %h want 0", out_result); end
        n_chk++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL rst_out_tag got %h want 0", out_tag); end
        n_chk++; if ({out_carry, out_overflow, out_zero} !== 3'b000) begin
            n_fail++; $display("FAIL rst_flags got %b want 000", {out_carry, out_overflow, out_zero}); end
        n_chk++; if ({alu_a, alu_b, alu_opcode} !== 67'd0) begin
            n_fail++; $display("FAIL rst_alu_ops got %h/%h/%h want 0", alu_a, alu_b, alu_opcode); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_pre got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready_post got %b want 1", in_ready); end
    endtask

    task automatic test_single_op();
        exp_q.delete(); got_q.delete();
        step(1'b1, 32'hFFFF_FFFF, 32'h1, OP_ADDU, 4'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            idle(1, 1'b1);
            if (k < 3) begin
                n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid k=%0d got %b want 0", k, out_valid); end
            end else if (k == 3) begin
                n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
                n_chk++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL single_result got %h want 0", out_result); end
                n_chk++; if ({out_carry, out_overflow, out_zero} !== 3'b101) begin
                    n_fail++; $display("FAIL single_flags got %b want 101", {out_carry, out_overflow, out_zero}); end
                n_chk++; if (out_tag !== 4'd3) begin n_fail++; $display("FAIL single_tag got %0d want 3", out_tag); end
            end
        end
        n_chk++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    endtask

    task automatic test_streaming();
        logic [31:0] a[8], b[8];
        int first = -1, last = -1, vcnt = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 18; i++) begin
            if (i < 8) begin
                a[i] = $urandom; b[i] = (i == 5) ? a[i] : $urandom;
                step(1'b1, a[i], b[i], OP_XOR, i[3:0], 1'b1, 1'b0);
            end else idle(1, 1'b1);
            if (out_valid) begin if (first < 0) first = cyc; last = cyc; vcnt++; end
        end
        n_chk++; if (exp_q.size() != 8) begin n_fail++; $display("FAIL stream_accepts got %0d want 8", exp_q.size()); end
        n_chk++; if (vcnt != 8 || last - first != 7) begin
            n_fail++; $display("FAIL stream_contiguous got %0d cycles span %0d want 8 span 7", vcnt, last - first); end
        n_chk++; if (got_q.size() != 8) begin n_fail++; $display("FAIL stream_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i].r !== (a[i] ^ b[i]) || got_q[i].t !== i[3:0] || got_q[i].z !== ((a[i] ^ b[i]) == 0)) begin
                n_fail++; $display("FAIL stream_item%0d got r=%h t=%0d z=%b want r=%h t=%0d", i,
                                   got_q[i].r, got_q[i].t, got_q[i].z, a[i] ^ b[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom, OP_ADDU, i[3:0], 1'b0, 1'b0);
        n_chk++; if (exp_q.size() != 6) begin n_fail++; $display("FAIL bp_accepts got %0d want 6", exp_q.size()); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            idle(1, 1'b0);
            n_chk++;
            if (out_valid !== 1'b1 || out_result !== exp_q[0].r || out_tag !== exp_q[0].t) begin
                n_fail++; $display("FAIL bp_hold k=%0d got v=%b r=%h t=%0d want v=1 r=%h t=%0d", k,
                                   out_valid, out_result, out_tag, exp_q[0].r, exp_q[0].t);
            end
        end
        idle(15, 1'b1);
        n_chk++; if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_drain_count got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_item%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] sb;
        int vcnt = 0;
        exp_q.delete(); got_q.delete();
        sb = $urandom_range(0, 31);
        step(1'b1, 32'h1, sb, OP_SHL, 4'd1, 1'b0, 1'b0);
        step(1'b1, $urandom, $urandom, OP_ADDU, 4'd2, 1'b0, 1'b0);
        step(1'b1, $urandom, $urandom, OP_OR, 4'd4, 1'b0, 1'b1);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_low got %b want 0", in_ready); end
        n_chk++; if (exp_q.size() != 2) begin n_fail++; $display("FAIL flush_accepts got %0d want 2", exp_q.size()); end
        idle(1, 1'b1);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_after got %b want 1", in_ready); end
        n_chk++; if (alu_a !== 32'h1 || alu_b !== sb || alu_opcode !== OP_SHL) begin
            n_fail++; $display("FAIL flush_alu_hold got %h/%h/%0d want 1/%h/7", alu_a, alu_b, alu_opcode, sb); end
        for (int k = 0; k < 6; k++) begin idle(1, 1'b1); if (out_valid) vcnt++; end
        n_chk++; if (vcnt != 0 || got_q.size() != 0) begin
            n_fail++; $display("FAIL flush_no_output got %0d valid cycles want 0", vcnt); end
        exp_q.delete();
        step(1'b1, 32'h5, 32'h7, OP_AND, 4'd9, 1'b1, 1'b0);
        idle(6, 1'b1);
        n_chk++; if (got_q.size() != 1 || got_q[0].r !== 32'h5 || got_q[0].t !== 4'd9) begin
            n_fail++; $display("FAIL flush_recover got %0d items want 1 with r=5 t=9", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        int vcnt = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, OP_SUBS, i[3:0], 1'b0, 1'b0);
        idle(1, 1'b0);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b want 1", out_valid); end
        reset_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 4'd0 ||
                     {out_carry, out_overflow, out_zero} !== 3'b000) begin
            n_fail++; $display("FAIL rmid_out got v=%b r=%h t=%0d want all 0", out_valid, out_result, out_tag); end
        n_chk++; if (in_ready !== 1'b0 || {alu_a, alu_b, alu_opcode} !== 67'd0) begin
            n_fail++; $display("FAIL rmid_in_alu got rdy=%b a=%h b=%h op=%0d want 0", in_ready, alu_a, alu_b, alu_opcode); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin idle(1, 1'b1); if (out_valid) vcnt++; end
        n_chk++; if (vcnt != 0 || got_q.size() != 0) begin
            n_fail++; $display("FAIL rmid_stale got %0d valid cycles want 0", vcnt); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        exp_q.delete();
    endtask

    task automatic test_random();
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 8 == 0) ? 32'd0 : $urandom,
                 3'($urandom_range(0, 7)), 4'($urandom), ($urandom % 10) < 7, 1'b0);
        idle(20, 1'b1);
        n_chk++; if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_item%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        idle(1, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'h1, OP_ADDS, 4'd0, 1'b1, 1'b0);
        step(1'b1, 32'h1, 32'h2, OP_ADDU, 4'd1, 1'b1, 1'b0);
        step(1'b1, 32'h8000_0000, 32'h8000_0000, OP_ADDS, 4'd2, 1'b1, 1'b0);
        step(1'b1, 32'h3, 32'h4, OP_ADDU, 4'd3, 1'b1, 1'b0);
        step(1'b1, 32'h9, 32'h1, OP_SUBU, 4'd4, 1'b1, 1'b0);
        idle(8, 1'b1);
        n_chk++; if (stat_issued !== 32'd5) begin n_fail++; $display("FAIL stat_issued got %0d want 5", stat_issued); end
        n_chk++; if (stat_ovf !== 16'd2) begin n_fail++; $display("FAIL stat_ovf got %0d want 2", stat_ovf); end
        step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b1, 1'b1);
        idle(2, 1'b1);
        n_chk++; if (stat_issued !== 32'd5 || stat_ovf !== 16'd2) begin
            n_fail++; $display("FAIL stat_flush_hold got %0d/%0d want 5/2", stat_issued, stat_ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
